// File: rtl/riscv_fetch_pkg.sv
// ============================================================================
// riscv_fetch_pkg : shared constants and fetch state encoding for the IF stage
// Revision 1.0
// ============================================================================
`default_nettype none

package riscv_fetch_pkg;

  localparam int          XLEN_DEFAULT = 64;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage : riscv_fetch_pkg

`default_nettype wire

// File: rtl/fetch_if_id_reg.sv
// ============================================================================
// fetch_if_id_reg : IF/ID pipeline register with flush > hold > load priority
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_if_id_reg
  import riscv_fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i && !hold_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule : fetch_if_id_reg

`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// instruction_fetch_stage : PC, fetch FSM and IF/ID for the RISC-V front end.
// Optional counters under FETCH_PERF_CNT_EN.                    Revision 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_stage
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_BYTES = 96
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] Instr_Addr,
  input  logic [31:0]     Instruction,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic            halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_count,
  output logic [31:0]     stall_count
`endif
);

  localparam logic [XLEN-1:0] c_imem_limit = XLEN'(IMEM_BYTES);
  localparam logic [XLEN-1:0] c_pc_step    = XLEN'(4);
  localparam logic [XLEN-1:0] c_align_mask = ~XLEN'(3);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            w_load;
  logic            w_flush;
  logic            w_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Redirect wins over everything, including HALT and a concurrent stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    w_load  = 1'b0;
    w_flush = 1'b0;
    w_hold  = 1'b0;
    if (redirect) begin
      pc_d    = redirect_pc & c_align_mask;
      w_flush = 1'b1;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: begin
          w_flush = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (pc_q >= c_imem_limit) begin
            w_flush = 1'b1;
            state_d = ST_HALT;
          end else if (stall) begin
            w_hold = 1'b1;
          end else begin
            w_load = 1'b1;
            pc_d   = pc_q + c_pc_step;
          end
        end
        ST_HALT: begin
          w_flush = 1'b1;
        end
        default: begin
          w_flush = 1'b1;
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  fetch_if_id_reg #(
    .XLEN (XLEN)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load_i  (w_load),
    .flush_i (w_flush),
    .hold_i  (w_hold),
    .pc_i    (pc_q),
    .instr_i (Instruction),
    .pc_o    (if_id_pc),
    .instr_o (if_id_instr),
    .valid_o (if_id_valid)
  );

  assign Instr_Addr = pc_q;
  assign halted     = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (w_load && (fetch_count_q != 32'hFFFF_FFFF)) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if ((state_q == ST_RUN) && stall && !redirect && (stall_count_q != 32'hFFFF_FFFF)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule : instruction_fetch_stage

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// tb_instruction_fetch_stage : directed self-checking bench for the IF stage
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

  localparam int XLEN = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            stall = 1'b0;
  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic [XLEN-1:0] Instr_Addr;
  logic [31:0]     Instruction;
  logic [XLEN-1:0] if_id_pc;
  logic [31:0]     if_id_instr;
  logic            if_id_valid;
  logic            halted;

  logic            s_stall = 1'b0;
  logic            s_redirect = 1'b0;
  logic [XLEN-1:0] s_redirect_pc = '0;
  logic [XLEN-1:0] s_addr;
  logic [31:0]     s_instr;
  logic [XLEN-1:0] s_pc;
  logic [31:0]     s_if_instr;
  logic            s_valid;
  logic            s_halted;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count, s_fetch_count, s_stall_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word tagged with its own address.
  assign Instruction = 32'h1000_0000 | Instr_Addr[31:0];
  assign s_instr     = 32'h2000_0000 | s_addr[31:0];

  instruction_fetch_stage #(.XLEN(XLEN), .RESET_PC('0), .IMEM_BYTES(96)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .Instr_Addr(Instr_Addr), .Instruction(Instruction),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  instruction_fetch_stage #(.XLEN(XLEN), .RESET_PC('0), .IMEM_BYTES(16)) dut16 (
    .clk(clk), .reset(reset), .stall(s_stall), .redirect(s_redirect),
    .redirect_pc(s_redirect_pc), .Instr_Addr(s_addr), .Instruction(s_instr),
    .if_id_pc(s_pc), .if_id_instr(s_if_instr), .if_id_valid(s_valid),
    .halted(s_halted)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(s_fetch_count), .stall_count(s_stall_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    s_stall = 1'b0; s_redirect = 1'b0; s_redirect_pc = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (Instr_Addr !== 64'h0 || if_id_valid !== 1'b0 || if_id_pc !== 64'h0 ||
        if_id_instr !== NOP || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: addr=%h valid=%b pc=%h instr=%h halted=%b required 0/0/0/%h/0",
               Instr_Addr, if_id_valid, if_id_pc, if_id_instr, halted, NOP);
    end
    tick();
    total++;
    if (if_id_valid !== 1'b0 || Instr_Addr !== 64'h0) begin
      bad++;
      $display("FAIL boot_cycle: valid=%b addr=%h required 0/0", if_id_valid, Instr_Addr);
    end
    tick();
    total++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0 || if_id_instr !== 32'h1000_0000) begin
      bad++;
      $display("FAIL first_fetch: valid=%b pc=%h instr=%h required 1/0/10000000",
               if_id_valid, if_id_pc, if_id_instr);
    end
    tick();
    total++;
    if (if_id_pc !== 64'h4 || if_id_instr !== 32'h1000_0004 || Instr_Addr !== 64'h8) begin
      bad++;
      $display("FAIL second_fetch: pc=%h instr=%h addr=%h required 4/10000004/8",
               if_id_pc, if_id_instr, Instr_Addr);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (Instr_Addr !== 64'h8 || if_id_pc !== 64'h4 || if_id_instr !== 32'h1000_0004 ||
          if_id_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold[%0d]: addr=%h pc=%h instr=%h valid=%b required 8/4/10000004/1",
                 i, Instr_Addr, if_id_pc, if_id_instr, if_id_valid);
      end
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 64'h22; stall = 1'b1;
    tick();
    total++;
    if (Instr_Addr !== 64'h20 || if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 64'h0) begin
      bad++;
      $display("FAIL redirect_flush: addr=%h valid=%b instr=%h pc=%h required 20/0/13/0",
               Instr_Addr, if_id_valid, if_id_instr, if_id_pc);
    end
    redirect = 1'b0; stall = 1'b0;
    tick();
    total++;
    if (if_id_pc !== 64'h20 || if_id_valid !== 1'b1 || if_id_instr !== 32'h1000_0020 ||
        Instr_Addr !== 64'h24) begin
      bad++;
      $display("FAIL redirect_target: pc=%h valid=%b instr=%h addr=%h required 20/1/10000020/24",
               if_id_pc, if_id_valid, if_id_instr, Instr_Addr);
    end
  endtask

  task automatic test_halt();
    logic [XLEN-1:0] exp_pc;
    do_reset();
    tick();  // boot
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = 64'(i * 4);
      total++;
      if (s_valid !== 1'b1 || s_pc !== exp_pc || s_halted !== 1'b0) begin
        bad++;
        $display("FAIL halt_fetch[%0d]: valid=%b pc=%h halted=%b required 1/%h/0",
                 i, s_valid, s_pc, s_halted, exp_pc);
      end
    end
    tick();
    total++;
    if (s_halted !== 1'b1 || s_valid !== 1'b0 || s_addr !== 64'd16 || s_if_instr !== NOP) begin
      bad++;
      $display("FAIL halt_enter: halted=%b valid=%b addr=%h instr=%h required 1/0/10/13",
               s_halted, s_valid, s_addr, s_if_instr);
    end
    s_stall = 1'b1;
    tick();
    tick();
    total++;
    if (s_halted !== 1'b1 || s_valid !== 1'b0 || s_addr !== 64'd16) begin
      bad++;
      $display("FAIL halt_hold: halted=%b valid=%b addr=%h required 1/0/10", s_halted, s_valid, s_addr);
    end
    s_redirect = 1'b1; s_redirect_pc = 64'h0;
    tick();
    total++;
    if (s_halted !== 1'b0 || s_addr !== 64'h0 || s_valid !== 1'b0) begin
      bad++;
      $display("FAIL halt_exit: halted=%b addr=%h valid=%b required 0/0/0", s_halted, s_addr, s_valid);
    end
    s_redirect = 1'b0; s_stall = 1'b0;
    tick();
    total++;
    if (s_valid !== 1'b1 || s_pc !== 64'h0 || s_if_instr !== 32'h2000_0000 || s_addr !== 64'h4) begin
      bad++;
      $display("FAIL halt_resume: valid=%b pc=%h instr=%h addr=%h required 1/0/20000000/4",
               s_valid, s_pc, s_if_instr, s_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (Instr_Addr !== 64'h0 || if_id_valid !== 1'b0 || if_id_pc !== 64'h0 ||
        if_id_instr !== NOP || halted !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: addr=%h valid=%b pc=%h instr=%h halted=%b required 0/0/0/13/0",
               Instr_Addr, if_id_valid, if_id_pc, if_id_instr, halted);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    total++;
    if (if_id_valid !== 1'b0 || Instr_Addr !== 64'h0) begin
      bad++;
      $display("FAIL async_boot: valid=%b addr=%h required 0/0", if_id_valid, Instr_Addr);
    end
    tick();
    total++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0 || Instr_Addr !== 64'h4) begin
      bad++;
      $display("FAIL async_refetch: valid=%b pc=%h addr=%h required 1/0/4", if_id_valid, if_id_pc, Instr_Addr);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    total++;
    if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
      bad++;
      $display("FAIL perf_reset: fetch=%0d stall=%0d required 0/0", fetch_count, stall_count);
    end
    tick();
    for (int i = 0; i < 4; i++) tick();
    stall = 1'b1;
    tick();
    tick();
    stall = 1'b0;
    total++;
    if (fetch_count !== 32'd4 || stall_count !== 32'd2) begin
      bad++;
      $display("FAIL perf_count: fetch=%0d stall=%0d required 4/2", fetch_count, stall_count);
    end
    dut.fetch_count_q = 32'hFFFF_FFFF;
    tick();
    total++;
    if (fetch_count !== 32'hFFFF_FFFF || if_id_valid !== 1'b1) begin
      bad++;
      $display("FAIL perf_saturate: fetch=%h valid=%b required ffffffff/1", fetch_count, if_id_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_halt();
    test_async_reset();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instruction_fetch_stage

`default_nettype wire
